// File: rtl/tile_scan_pkg.sv
// Shared timing constants, default tile geometry and helper types for the
// tile background scan path.
package tile_scan_pkg;

    localparam int VGA_H_ACTIVE = 32'd640;
    localparam int VGA_H_FP     = 32'd16;
    localparam int VGA_H_SYNC   = 32'd96;
    localparam int VGA_H_BP     = 32'd48;
    localparam int VGA_V_ACTIVE = 32'd480;
    localparam int VGA_V_FP     = 32'd10;
    localparam int VGA_V_SYNC   = 32'd2;
    localparam int VGA_V_BP     = 32'd33;

    localparam int TILE_LOG2_DEF = 32'd3;
    localparam int GRID_W_DEF    = 32'd80;
    localparam int GRID_H_DEF    = 32'd60;
    localparam int LOOKAHEAD_DEF = 32'd2;

    typedef struct packed {
        logic [7:0] tx;
        logic [7:0] ty;
    } tile_coord_t;

    // Smallest address width able to index every tile of the grid.
    function automatic int calc_addr_w(input int cells);
        int w;
        w = 32'd1;
        while ((64'd1 << w) < 64'(cells)) begin
            w = w + 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/tile_scan_if.sv
// Beam/scroll/address bundle between the scan unit (master) and its consumers
// (slave): background memory read port and frame-boundary control.
interface tile_scan_if #(
    parameter int ADDR_W = 32'd13
);
    logic              pixel_en;
    logic [9:0]        scroll_x;
    logic [9:0]        scroll_y;
    logic              hsync;
    logic              vsync;
    logic              video_enable;
    logic [9:0]        pixel_x;
    logic [9:0]        pixel_y;
    logic [ADDR_W-1:0] addr_block;
    logic              addr_valid;
    logic              frame_done;
    logic              frame_start;

    modport master (
        input  pixel_en, scroll_x, scroll_y,
        output hsync, vsync, video_enable, pixel_x, pixel_y,
               addr_block, addr_valid, frame_done, frame_start
    );

    modport slave (
        output pixel_en, scroll_x, scroll_y,
        input  hsync, vsync, video_enable, pixel_x, pixel_y,
               addr_block, addr_valid, frame_done, frame_start
    );
endinterface

// File: rtl/tile_addr_pipe.sv
// Two-stage pipeline turning the beam position into the tile address of the
// pixel LOOKAHEAD positions ahead, with toroidal wrap of the tile map.
module tile_addr_pipe
    import tile_scan_pkg::*;
#(
    parameter int H_TOTAL   = 32'd800,
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int V_TOTAL   = 32'd525,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int TILE_LOG2 = TILE_LOG2_DEF,
    parameter int GRID_W    = GRID_W_DEF,
    parameter int GRID_H    = GRID_H_DEF,
    parameter int ADDR_W    = 32'd13,
    parameter int LOOKAHEAD = LOOKAHEAD_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        h,
    input  logic [9:0]        v,
    input  logic [9:0]        sx,
    input  logic [9:0]        sy,
    output logic [ADDR_W-1:0] addr_block,
    output logic              addr_valid
);

    logic [10:0]       lh_sum_s;
    logic [9:0]        lh_s;
    logic [9:0]        lv_s;
    logic [10:0]       mx_s;
    logic [10:0]       my_s;
    logic              la_valid_s;
    logic [10:0]       mx_r;
    logic [10:0]       my_r;
    logic              valid1_r;
    logic [10:0]       tx_raw_s;
    logic [10:0]       ty_raw_s;
    tile_coord_t       tc_s;
    logic [ADDR_W-1:0] addr_s;
    logic [ADDR_W-1:0] addr_r;
    logic              valid2_r;

    // Lookahead coordinate, wrapping past the end of the line onto the next one.
    always_comb begin
        lh_sum_s = {1'b0, h} + 11'(LOOKAHEAD);
        lh_s     = lh_sum_s[9:0];
        lv_s     = v;
        if (lh_sum_s >= 11'(H_TOTAL)) begin
            lh_s = 10'(lh_sum_s - 11'(H_TOTAL));
            if (v >= 10'(V_TOTAL - 1)) begin
                lv_s = 10'd0;
            end else begin
                lv_s = v + 10'd1;
            end
        end else begin
            lh_s = lh_sum_s[9:0];
        end
        mx_s       = {1'b0, lh_s} + {1'b0, sx};
        my_s       = {1'b0, lv_s} + {1'b0, sy};
        la_valid_s = (lh_s < 10'(H_ACTIVE)) && (lv_s < 10'(V_ACTIVE));
    end

    // Stage 1: map coordinate and visibility of the lookahead pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mx_r     <= 11'd0;
            my_r     <= 11'd0;
            valid1_r <= 1'b0;
        end else begin
            mx_r     <= mx_s;
            my_r     <= my_s;
            valid1_r <= la_valid_s;
        end
    end

    // Scroll offsets are bounded by the map size, so one subtract is a full modulo.
    always_comb begin
        tc_s     = 16'd0;
        tx_raw_s = mx_r >> TILE_LOG2;
        ty_raw_s = my_r >> TILE_LOG2;
        if (tx_raw_s >= 11'(GRID_W)) begin
            tc_s.tx = 8'(tx_raw_s - 11'(GRID_W));
        end else begin
            tc_s.tx = 8'(tx_raw_s);
        end
        if (ty_raw_s >= 11'(GRID_H)) begin
            tc_s.ty = 8'(ty_raw_s - 11'(GRID_H));
        end else begin
            tc_s.ty = 8'(ty_raw_s);
        end
        addr_s = ADDR_W'(16'(tc_s.ty) * 16'(GRID_W) + 16'(tc_s.tx));
    end

    // Stage 2: address register, held while the lookahead pixel is off-screen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r   <= {ADDR_W{1'b0}};
            valid2_r <= 1'b0;
        end else begin
            valid2_r <= valid1_r;
            if (valid1_r) begin
                addr_r <= addr_s;
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    assign addr_block = addr_r;
    assign addr_valid = valid2_r;

endmodule

// File: rtl/tile_scan_unit.sv
// VGA beam counters, syncs, per-frame scroll latch and frame pulses driving the
// tile address pipeline. Define SCROLL_EN to enable per-frame scrolling.
module tile_scan_unit
    import tile_scan_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int TILE_LOG2 = TILE_LOG2_DEF,
    parameter int GRID_W    = GRID_W_DEF,
    parameter int GRID_H    = GRID_H_DEF,
    parameter int ADDR_W    = calc_addr_w(GRID_W * GRID_H),
    parameter int LOOKAHEAD = LOOKAHEAD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    tile_scan_if.master bus
);

    localparam int         H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_C    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_C    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]        h_r;
    logic [9:0]        v_r;
    logic [9:0]        h_nxt_s;
    logic [9:0]        v_nxt_s;
    logic              frame_wrap_s;
    logic              frame_end_s;
    logic              hsync_r;
    logic              vsync_r;
    logic              video_en_r;
    logic              frame_done_r;
    logic              frame_start_r;
    logic [9:0]        sx_s;
    logic [9:0]        sy_s;
    logic [ADDR_W-1:0] addr_s;
    logic              addr_valid_s;

    // Next beam position; >= keeps the counters in range even if corrupted.
    always_comb begin
        h_nxt_s      = h_r + 10'd1;
        v_nxt_s      = v_r;
        frame_wrap_s = 1'b0;
        if (h_r >= H_LAST) begin
            h_nxt_s = 10'd0;
            if (v_r >= V_LAST) begin
                v_nxt_s      = 10'd0;
                frame_wrap_s = 1'b1;
            end else begin
                v_nxt_s = v_r + 10'd1;
            end
        end else begin
            h_nxt_s = h_r + 10'd1;
        end
        frame_end_s = (h_r == H_ACT_C - 10'd1) && (v_r == V_ACT_C - 10'd1);
    end

    // Beam counters with syncs, video enable and frame pulses derived from the new position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_r           <= 10'd0;
            v_r           <= 10'd0;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            video_en_r    <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (bus.pixel_en) begin
            h_r           <= h_nxt_s;
            v_r           <= v_nxt_s;
            hsync_r       <= !((h_nxt_s >= HS_START) && (h_nxt_s < HS_END));
            vsync_r       <= !((v_nxt_s >= VS_START) && (v_nxt_s < VS_END));
            video_en_r    <= (h_nxt_s < H_ACT_C) && (v_nxt_s < V_ACT_C);
            frame_done_r  <= frame_end_s;
            frame_start_r <= frame_wrap_s;
        end else begin
            frame_done_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end
    end

`ifdef SCROLL_EN
    logic [9:0] sx_l_r;
    logic [9:0] sy_l_r;

    // Scroll offsets are captured only at the frame wrap so a frame never tears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sx_l_r <= 10'd0;
            sy_l_r <= 10'd0;
        end else if (bus.pixel_en && frame_wrap_s) begin
            sx_l_r <= bus.scroll_x;
            sy_l_r <= bus.scroll_y;
        end else begin
            sx_l_r <= sx_l_r;
            sy_l_r <= sy_l_r;
        end
    end

    assign sx_s = sx_l_r;
    assign sy_s = sy_l_r;
`else
    logic scroll_unused_s;

    assign scroll_unused_s = ^{bus.scroll_x, bus.scroll_y};
    assign sx_s            = 10'd0;
    assign sy_s            = 10'd0;
`endif

    tile_addr_pipe #(
        .H_TOTAL   (H_TOTAL),
        .H_ACTIVE  (H_ACTIVE),
        .V_TOTAL   (V_TOTAL),
        .V_ACTIVE  (V_ACTIVE),
        .TILE_LOG2 (TILE_LOG2),
        .GRID_W    (GRID_W),
        .GRID_H    (GRID_H),
        .ADDR_W    (ADDR_W),
        .LOOKAHEAD (LOOKAHEAD)
    ) u_addr_pipe (
        .clk        (clk),
        .reset      (reset),
        .h          (h_r),
        .v          (v_r),
        .sx         (sx_s),
        .sy         (sy_s),
        .addr_block (addr_s),
        .addr_valid (addr_valid_s)
    );

    assign bus.hsync        = hsync_r;
    assign bus.vsync        = vsync_r;
    assign bus.video_enable = video_en_r;
    assign bus.pixel_x      = h_r;
    assign bus.pixel_y      = v_r;
    assign bus.frame_done   = frame_done_r;
    assign bus.frame_start  = frame_start_r;
    assign bus.addr_block   = addr_s;
    assign bus.addr_valid   = addr_valid_s;

endmodule

// File: tb/tb_tile_scan_unit.sv
// Bench for tile_scan_unit: a default 640x480 instance plus a shrunken-timing
// instance (full frames fit in a short run), both checked against a reference model.
module tb_tile_scan_unit;

    typedef struct {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        int tl; int gw; int gh; int la;
    } cfg_t;

    typedef struct {
        int h; int v; int sx; int sy;
        int last_addr; int act_cnt;
        bit fd; bit fs;
    } mstate_t;

`ifdef SCROLL_EN
    localparam bit SCROLL_MODEL = 1'b1;
`else
    localparam bit SCROLL_MODEL = 1'b0;
`endif

    logic    clk = 1'b0;
    logic    reset;
    int      tests = 0;
    int      fails = 0;
    cfg_t    cd;
    cfg_t    cs;
    mstate_t md;
    mstate_t ms;
    bit      s_done_seen;

    always #5 clk = ~clk;

    tile_scan_if #(.ADDR_W(13)) bus_d ();
    tile_scan_if #(.ADDR_W(4))  bus_s ();

    tile_scan_unit dut_d (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_d.master)
    );

    tile_scan_unit #(
        .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .TILE_LOG2(3), .GRID_W(4), .GRID_H(3), .ADDR_W(4), .LOOKAHEAD(5)
    ) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic mstate_t model_reset();
        mstate_t s;
        s.h = 0; s.v = 0; s.sx = 0; s.sy = 0;
        s.last_addr = 0; s.act_cnt = 0; s.fd = 1'b0; s.fs = 1'b0;
        return s;
    endfunction

    // One strobe: treat the beam as a linear index into the frame.
    function automatic mstate_t adv(input cfg_t c, input mstate_t s, input int in_sx, input int in_sy);
        mstate_t n;
        int ht, vt, pos;
        n  = s;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        n.fd = (s.h == c.ha - 1) && (s.v == c.va - 1);
        if (s.h < c.ha && s.v < c.va) n.act_cnt = s.act_cnt + 1;
        pos  = (s.v * ht + s.h + 1) % (ht * vt);
        n.fs = (pos == 0);
        n.h  = pos % ht;
        n.v  = pos / ht;
        if (n.fs) begin
            n.sx = SCROLL_MODEL ? in_sx : 0;
            n.sy = SCROLL_MODEL ? in_sy : 0;
        end
        return n;
    endfunction

    function automatic void exp_addr(input cfg_t c, input mstate_t s, output bit valid, output int addr);
        int ht, vt, idx, lh, lv;
        ht    = c.ha + c.hf + c.hs + c.hb;
        vt    = c.va + c.vf + c.vs + c.vb;
        idx   = (s.v * ht + s.h + c.la) % (ht * vt);
        lh    = idx % ht;
        lv    = idx / ht;
        valid = (lh < c.ha) && (lv < c.va);
        addr  = (((lv + s.sy) / (1 << c.tl)) % c.gh) * c.gw + ((lh + s.sx) / (1 << c.tl)) % c.gw;
    endfunction

    task automatic chk_beam(input string nm, input cfg_t c, input mstate_t s,
                            input logic [9:0] px, input logic [9:0] py, input logic hs,
                            input logic vs, input logic ve, input logic fd, input logic fs);
        int hss, vss;
        hss = c.ha + c.hf;
        vss = c.va + c.vf;
        chk({nm, "_pixel_x"}, 32'(px), 32'(s.h));
        chk({nm, "_pixel_y"}, 32'(py), 32'(s.v));
        chk({nm, "_hsync"}, 32'(hs), 32'(!(s.h >= hss && s.h < hss + c.hs)));
        chk({nm, "_vsync"}, 32'(vs), 32'(!(s.v >= vss && s.v < vss + c.vs)));
        chk({nm, "_video_enable"}, 32'(ve), 32'(s.h < c.ha && s.v < c.va));
        chk({nm, "_frame_done"}, 32'(fd), 32'(s.fd));
        chk({nm, "_frame_start"}, 32'(fs), 32'(s.fs));
    endtask

    task automatic chk_addr(input string nm, input cfg_t c, inout mstate_t s,
                            input logic [15:0] ab, input logic av);
        bit valid;
        int addr;
        exp_addr(c, s, valid, addr);
        if (valid) s.last_addr = addr;
        chk({nm, "_addr_valid"}, 32'(av), 32'(valid));
        chk({nm, "_addr_block"}, 32'(ab), 32'(s.last_addr));
    endtask

    task automatic chk_reset(input string nm, input logic [9:0] px, input logic [9:0] py,
                             input logic hs, input logic vs, input logic ve, input logic av,
                             input logic fd, input logic fs, input logic [15:0] ab);
        chk({nm, "_rst_pixel_x"}, 32'(px), 32'd0);
        chk({nm, "_rst_pixel_y"}, 32'(py), 32'd0);
        chk({nm, "_rst_hsync"}, 32'(hs), 32'd1);
        chk({nm, "_rst_vsync"}, 32'(vs), 32'd1);
        chk({nm, "_rst_video_enable"}, 32'(ve), 32'd0);
        chk({nm, "_rst_addr_valid"}, 32'(av), 32'd0);
        chk({nm, "_rst_frame_done"}, 32'(fd), 32'd0);
        chk({nm, "_rst_frame_start"}, 32'(fs), 32'd0);
        chk({nm, "_rst_addr_block"}, 32'(ab), 32'd0);
    endtask

    task automatic chk_reset_both();
        chk_reset("dflt", bus_d.pixel_x, bus_d.pixel_y, bus_d.hsync, bus_d.vsync,
                  bus_d.video_enable, bus_d.addr_valid, bus_d.frame_done,
                  bus_d.frame_start, 16'(bus_d.addr_block));
        chk_reset("small", bus_s.pixel_x, bus_s.pixel_y, bus_s.hsync, bus_s.vsync,
                  bus_s.video_enable, bus_s.addr_valid, bus_s.frame_done,
                  bus_s.frame_start, 16'(bus_s.addr_block));
    endtask

    task automatic do_strobe();
        @(negedge clk);
        bus_d.pixel_en = 1'b1;
        bus_s.pixel_en = 1'b1;
        @(negedge clk);
        bus_d.pixel_en = 1'b0;
        bus_s.pixel_en = 1'b0;
        md = adv(cd, md, int'(bus_d.scroll_x), int'(bus_d.scroll_y));
        ms = adv(cs, ms, int'(bus_s.scroll_x), int'(bus_s.scroll_y));
        chk_beam("dflt", cd, md, bus_d.pixel_x, bus_d.pixel_y, bus_d.hsync, bus_d.vsync,
                 bus_d.video_enable, bus_d.frame_done, bus_d.frame_start);
        chk_beam("small", cs, ms, bus_s.pixel_x, bus_s.pixel_y, bus_s.hsync, bus_s.vsync,
                 bus_s.video_enable, bus_s.frame_done, bus_s.frame_start);
        if (bus_s.frame_done === 1'b1 && !s_done_seen) begin
            s_done_seen = 1'b1;
            chk("small_first_done_active_strobes", 32'(ms.act_cnt), 32'(cs.ha * cs.va));
        end
        @(negedge clk);
        chk("dflt_pulse_width", 32'({bus_d.frame_done, bus_d.frame_start}), 32'd0);
        chk("small_pulse_width", 32'({bus_s.frame_done, bus_s.frame_start}), 32'd0);
        @(negedge clk);
        chk_addr("dflt", cd, md, 16'(bus_d.addr_block), bus_d.addr_valid);
        chk_addr("small", cs, ms, 16'(bus_s.addr_block), bus_s.addr_valid);
        if (md.h == 6 && md.v == 0) chk("dflt_beam_6_0_addr", 32'(bus_d.addr_block), 32'd1);
        if (md.h == 0 && md.v == 8) chk("dflt_beam_0_8_addr", 32'(bus_d.addr_block), 32'd80);
        if (md.h == 798 && md.v == 10) begin
            chk("dflt_wrap_798_10_valid", 32'(bus_d.addr_valid), 32'd1);
            chk("dflt_wrap_798_10_addr", 32'(bus_d.addr_block), 32'd80);
        end
    endtask

    task automatic run_strobes(input int n);
        for (int i = 0; i < n; i++) begin
            if (i % 150 == 75) begin
                bus_d.scroll_x = 10'($urandom_range(0, 639));
                bus_d.scroll_y = 10'($urandom_range(0, 479));
                bus_s.scroll_x = 10'($urandom_range(0, 31));
                bus_s.scroll_y = 10'($urandom_range(0, 23));
            end
            do_strobe();
        end
    endtask

    initial begin
        cd = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, tl:3, gw:80, gh:60, la:2};
        cs = '{ha:32, hf:2, hs:4, hb:2, va:24, vf:2, vs:2, vb:2, tl:3, gw:4, gh:3, la:5};
        reset          = 1'b0;
        bus_d.pixel_en = 1'b0;
        bus_s.pixel_en = 1'b0;
        bus_d.scroll_x = 10'd0;
        bus_d.scroll_y = 10'd0;
        bus_s.scroll_x = 10'd0;
        bus_s.scroll_y = 10'd16;
        md = model_reset();
        ms = model_reset();
        s_done_seen = 1'b0;

        // Power-on reset values.
        repeat (3) @(negedge clk);
        chk_reset_both();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_addr("dflt_post_reset", cd, md, 16'(bus_d.addr_block), bus_d.addr_valid);
        chk_addr("small_post_reset", cs, ms, 16'(bus_s.addr_block), bus_s.addr_valid);
        chk("dflt_beam_0_0_addr", 32'(bus_d.addr_block), 32'd0);

        // First small frame (with scroll latched at its end) and part of the next.
        run_strobes(1700);

        // Mid-frame reset: outputs must clear asynchronously.
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_both();
        @(negedge clk);
        @(negedge clk);
        chk_reset_both();
        reset = 1'b1;
        md = model_reset();
        ms = model_reset();
        s_done_seen = 1'b0;
        repeat (3) @(negedge clk);
        chk_addr("dflt_rerelease", cd, md, 16'(bus_d.addr_block), bus_d.addr_valid);
        chk_addr("small_rerelease", cs, ms, 16'(bus_s.addr_block), bus_s.addr_valid);

        // Long run: default instance reaches line 11, small one wraps several frames.
        run_strobes(8900);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
